// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master adapter FSM state type.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {WIDTH{1'b1}}))
            cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/axi4_lite_master_adapter.sv
// Single-outstanding request/response to AXI4-Lite master bridge.
// Optional transaction statistics outputs under AXI4_LITE_MASTER_STATS_EN.
//
// state      | meaning
// IDLE       | ready for a request
// WR_AW_W    | AW and W presented, each dropped after its own handshake
// WR_B       | waiting for write response
// RD_AR      | AR presented
// RD_R       | waiting for read data
// RSP        | response held until consumed
module axi4_lite_master_adapter
    import axi4_lite_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_BYTE_COUNT = AXI_DATA_WIDTH / 8,
    parameter int MASTER_ID      = 0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [AXI_DATA_WIDTH-1:0] req_wdata,
    input  logic [AXI_BYTE_COUNT-1:0] req_wstrb,
    input  logic [2:0]                req_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [AXI_ID_WIDTH-1:0]   awid,
    output logic [AXI_ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [AXI_DATA_WIDTH-1:0] wdata,
    output logic [AXI_BYTE_COUNT-1:0] wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [AXI_ID_WIDTH-1:0]   bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic [AXI_ID_WIDTH-1:0]   arid,
    output logic [AXI_ADDR_WIDTH-1:0] araddr,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [AXI_ID_WIDTH-1:0]   rid,
    input  logic [AXI_DATA_WIDTH-1:0] rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    output logic                      rready
`ifdef AXI4_LITE_MASTER_STATS_EN
    ,
    output logic [31:0]               stat_wr_cnt,
    output logic [31:0]               stat_rd_cnt,
    output logic [31:0]               stat_err_cnt
`endif
);

    localparam logic [AXI_ID_WIDTH-1:0] MID = AXI_ID_WIDTH'(MASTER_ID);

    state_e                    state_q, state_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      arvalid_q, arvalid_d;
    logic                      bready_q, bready_d;
    logic                      rready_q, rready_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [AXI_BYTE_COUNT-1:0] wstrb_q, wstrb_d;
    logic [2:0]                prot_q, prot_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                rsp_resp_q, rsp_resp_d;
    logic                      aw_done, w_done;

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        prot_d      = prot_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        // A valid that is already low in WR_AW_W means that channel has handshaken.
        aw_done     = !awvalid_q || awready;
        w_done      = !wvalid_q || wready;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    prot_d  = req_prot;
                    if (req_write) begin
                        state_d   = ST_WR_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR_AW_W: begin
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = ST_WR_B;
                    bready_d = 1'b1;
                end
            end
            ST_WR_B: begin
                if (bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = (bid != MID) ? RESP_SLVERR : bresp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RD_AR: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_R;
                end
            end
            ST_RD_R: begin
                if (rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = (rid != MID) ? RESP_SLVERR : rresp;
                    rsp_rdata_d = rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            prot_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            prot_q      <= prot_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign awid      = MID;
    assign awaddr    = addr_q;
    assign awprot    = prot_q;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign arid      = MID;
    assign araddr    = addr_q;
    assign arprot    = prot_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;

`ifdef AXI4_LITE_MASTER_STATS_EN
    logic wr_txn_q;
    logic rsp_hs;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                                  wr_txn_q <= 1'b0;
        else if ((state_q == ST_IDLE) && req_valid)    wr_txn_q <= req_write;
    end

    assign rsp_hs = rsp_valid_q && rsp_ready;

    sat_counter #(.WIDTH(32)) u_stat_wr (
        .clk(aclk), .rst_n(aresetn), .inc(rsp_hs && wr_txn_q), .cnt(stat_wr_cnt)
    );
    sat_counter #(.WIDTH(32)) u_stat_rd (
        .clk(aclk), .rst_n(aresetn), .inc(rsp_hs && !wr_txn_q), .cnt(stat_rd_cnt)
    );
    sat_counter #(.WIDTH(32)) u_stat_err (
        .clk(aclk), .rst_n(aresetn), .inc(rsp_hs && rsp_resp_q[1]), .cnt(stat_err_cnt)
    );
`endif

endmodule

// File: tb/tb_axi4_lite_master_adapter.sv
// Self-checking bench for axi4_lite_master_adapter: directed table, timing sequences,
// randomized transactions against a spec-level model; stats checks under AXI4_LITE_MASTER_STATS_EN.
module tb_axi4_lite_master_adapter;

    localparam int MASTER_ID = 0;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req_valid, req_ready, req_write;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_prot;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [0:0]  awid, bid, arid, rid;
    logic [11:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
`ifdef AXI4_LITE_MASTER_STATS_EN
    logic [31:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

    always #5 aclk = ~aclk;

    axi4_lite_master_adapter #(.MASTER_ID(MASTER_ID)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awid(awid), .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef AXI4_LITE_MASTER_STATS_EN
        , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_err_cnt(stat_err_cnt)
`endif
    );

    typedef struct {
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [2:0]  prot;
        logic [0:0]  id;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [11:0] awaddr, araddr;
        logic [2:0]  awprot, arprot;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          rsp_first, aw_last, w_last, bready_first;
        int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        logic        stable_err, rr_err, timeout;
    } obs_t;

    int tests = 0;
    int failed = 0;
    int n_wr = 0, n_rd = 0, n_err = 0;

    vec_t vecs[8];
    obs_t obs_arr[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Spec-level expectation: ID mismatch forces SLVERR, writes return zero data.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_resp  = (int'(v.id) != MASTER_ID) ? 2'b10 : v.resp;
        r.exp_rdata = v.write ? 32'h0 : v.rdata;
        return r;
    endfunction

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0; req_prot = '0;
        rsp_ready = 0; awready = 0; wready = 0; arready = 0;
        bvalid = 0; bid = '0; bresp = '0; rvalid = 0; rid = '0; rdata = '0; rresp = '0;
    endtask

    task automatic run_txn(input vec_t v, output obs_t o);
        int   cyc, aw_w, w_w, b_w, ar_w, r_w, rs_w;
        logic b_armed, b_on, r_armed, r_on, done, b_hs, r_hs;
        o = '0;
        cyc = 0; aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0; rs_w = 0;
        b_armed = 0; b_on = 0; r_armed = 0; r_on = 0; done = 0;
        @(negedge aclk);
        req_valid = 1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
        req_wstrb = v.wstrb; req_prot = v.prot;
        @(posedge aclk);
        #1 req_valid = 0;
        while (!done && cyc < 200) begin
            @(negedge aclk);
            cyc++;
            if (req_ready) o.rr_err = 1;
            awready = 0; wready = 0; arready = 0; rsp_ready = 0;
            if (awvalid) begin
                o.aw_last = cyc; o.awaddr = awaddr; o.awprot = awprot;
                if (aw_w >= v.aw_dly) begin awready = 1; o.aw_cnt++; end else aw_w++;
            end
            if (wvalid) begin
                o.w_last = cyc; o.wdata = wdata; o.wstrb = wstrb;
                if (w_w >= v.w_dly) begin wready = 1; o.w_cnt++; end else w_w++;
            end
            if (arvalid) begin
                o.araddr = araddr; o.arprot = arprot;
                if (ar_w >= v.ar_dly) begin arready = 1; o.ar_cnt++; end else ar_w++;
            end
            if (bready && o.bready_first == 0) o.bready_first = cyc;
            if (b_armed && !b_on && o.b_cnt == 0) begin
                if (b_w >= v.b_dly) b_on = 1; else b_w++;
            end
            bvalid = b_on; bid = v.id; bresp = v.resp;
            b_hs = b_on && bready;
            if (b_hs) o.b_cnt++;
            if (r_armed && !r_on && o.r_cnt == 0) begin
                if (r_w >= v.r_dly) r_on = 1; else r_w++;
            end
            rvalid = r_on; rid = v.id; rresp = v.resp; rdata = v.rdata;
            r_hs = r_on && rready;
            if (r_hs) o.r_cnt++;
            if (rsp_valid) begin
                if (o.rsp_first == 0) begin
                    o.rsp_first = cyc; o.resp = rsp_resp; o.rdata = rsp_rdata;
                end else if (rsp_resp !== o.resp || rsp_rdata !== o.rdata) begin
                    o.stable_err = 1;
                end
                if (rs_w >= v.rsp_dly) begin rsp_ready = 1; done = 1; end else rs_w++;
            end
            if (b_hs) b_on = 0;
            if (r_hs) r_on = 0;
            if (o.aw_cnt > 0 && o.w_cnt > 0) b_armed = 1;
            if (o.ar_cnt > 0) r_armed = 1;
        end
        @(posedge aclk);
        #1 idle_inputs();
        o.timeout = !done;
    endtask

    task automatic check_txn(input string tag, input vec_t v, input obs_t o);
        chk({tag, "_timeout"}, o.timeout, 0);
        chk({tag, "_resp"}, o.resp, v.exp_resp);
        chk({tag, "_rdata"}, o.rdata, v.exp_rdata);
        chk({tag, "_rsp_stable"}, o.stable_err, 0);
        chk({tag, "_req_ready_busy"}, o.rr_err, 0);
        if (v.write) begin
            chk({tag, "_aw_hs"}, o.aw_cnt, 1);
            chk({tag, "_w_hs"}, o.w_cnt, 1);
            chk({tag, "_b_hs"}, o.b_cnt, 1);
            chk({tag, "_ar_hs"}, o.ar_cnt, 0);
            chk({tag, "_awaddr"}, o.awaddr, v.addr);
            chk({tag, "_awprot"}, o.awprot, v.prot);
            chk({tag, "_wdata"}, o.wdata, v.wdata);
            chk({tag, "_wstrb"}, o.wstrb, v.wstrb);
        end else begin
            chk({tag, "_ar_hs"}, o.ar_cnt, 1);
            chk({tag, "_r_hs"}, o.r_cnt, 1);
            chk({tag, "_aw_hs"}, o.aw_cnt, 0);
            chk({tag, "_araddr"}, o.araddr, v.addr);
            chk({tag, "_arprot"}, o.arprot, v.prot);
        end
        @(negedge aclk);
        chk({tag, "_req_ready_after"}, req_ready, 1);
        chk({tag, "_rsp_valid_after"}, rsp_valid, 0);
        if (!o.timeout) begin
            if (v.write) n_wr++; else n_rd++;
            if (v.exp_resp[1]) n_err++;
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [11:0] a, input logic [31:0] wd,
                                input logic [3:0] st, input logic [2:0] pr, input logic [0:0] id,
                                input logic [1:0] rs, input logic [31:0] rd,
                                input int awd, input int wd_dly, input int ard, input int rdl,
                                input int rspd, input logic [1:0] er, input logic [31:0] erd);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.wstrb = st; v.prot = pr; v.id = id;
        v.resp = rs; v.rdata = rd; v.aw_dly = awd; v.w_dly = wd_dly; v.b_dly = 0;
        v.ar_dly = ard; v.r_dly = rdl; v.rsp_dly = rspd; v.exp_resp = er; v.exp_rdata = erd;
        return v;
    endfunction

    initial begin
        vec_t v;
        obs_t o;
        logic flag;

        vecs[0] = mk(1, 12'h010, 32'hDEADBEEF, 4'hF, 3'd0, 1'b0, 2'b00, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 2'b00, 32'h0);
        vecs[1] = mk(0, 12'h024, 32'h0,        4'h0, 3'd0, 1'b0, 2'b00, 32'h12345678, 0, 0, 0, 0, 3, 2'b00, 32'h12345678);
        vecs[2] = mk(0, 12'h100, 32'h0,        4'h0, 3'd3, 1'b1, 2'b00, 32'hCAFEF00D, 0, 0, 0, 0, 0, 2'b10, 32'hCAFEF00D);
        vecs[3] = mk(1, 12'h200, 32'h0BADF00D, 4'h3, 3'd2, 1'b0, 2'b11, 32'h0,        0, 0, 0, 0, 1, 2'b11, 32'h0);
        vecs[4] = mk(1, 12'h004, 32'h00000001, 4'h1, 3'd1, 1'b1, 2'b01, 32'h0,        1, 2, 0, 0, 0, 2'b10, 32'h0);
        vecs[5] = mk(0, 12'h0FC, 32'h0,        4'h0, 3'd5, 1'b0, 2'b01, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 2'b01, 32'hA5A5A5A5);
        vecs[6] = mk(1, 12'h030, 32'h55AA55AA, 4'hC, 3'd0, 1'b0, 2'b00, 32'h0,        0, 3, 0, 0, 0, 2'b00, 32'h0);
        vecs[7] = mk(0, 12'hFFC, 32'h0,        4'h0, 3'd7, 1'b0, 2'b10, 32'h87654321, 0, 0, 2, 3, 0, 2'b10, 32'h87654321);

        idle_inputs();
        aresetn = 0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_resp", rsp_resp, 2'b00);
        chk("rst_ids", {awid, arid}, 2'b00);
        repeat (3) @(negedge aclk);
        aresetn = 1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], obs_arr[i]);
            check_txn($sformatf("vec%0d", i), vecs[i], obs_arr[i]);
        end

        chk("wr_min_aw_cycle", obs_arr[0].aw_last, 1);
        chk("wr_min_w_cycle", obs_arr[0].w_last, 1);
        chk("wr_min_bready_cycle", obs_arr[0].bready_first, 2);
        chk("wr_min_rsp_cycle", obs_arr[0].rsp_first, 3);
        chk("rd_min_rsp_cycle", obs_arr[1].rsp_first, 3);
        chk("wr_wdly_aw_last", obs_arr[6].aw_last, 1);
        chk("wr_wdly_w_last", obs_arr[6].w_last, 4);
        chk("wr_wdly_bready_first", obs_arr[6].bready_first, 5);
        chk("wr_wdly_rsp_cycle", obs_arr[6].rsp_first, 6);

        for (int i = 0; i < 40; i++) begin
            v.write = 1'($urandom_range(0, 1));
            v.addr = 12'($urandom); v.wdata = $urandom; v.wstrb = 4'($urandom);
            v.prot = 3'($urandom); v.id = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            v.resp = 2'($urandom); v.rdata = $urandom;
            v.aw_dly = $urandom_range(0, 3); v.w_dly = $urandom_range(0, 3);
            v.b_dly = $urandom_range(0, 3); v.ar_dly = $urandom_range(0, 3);
            v.r_dly = $urandom_range(0, 3); v.rsp_dly = $urandom_range(0, 2);
            v = model(v);
            run_txn(v, o);
            check_txn($sformatf("rnd%0d", i), v, o);
        end

`ifdef AXI4_LITE_MASTER_STATS_EN
        chk("stat_wr", stat_wr_cnt, 32'(n_wr));
        chk("stat_rd", stat_rd_cnt, 32'(n_rd));
        chk("stat_err", stat_err_cnt, 32'(n_err));
        @(negedge aclk);
        force dut.u_stat_wr.cnt_q = 32'hFFFF_FFFF;
        @(posedge aclk);
        #1 release dut.u_stat_wr.cnt_q;
        run_txn(vecs[0], o);
        check_txn("sat", vecs[0], o);
        chk("stat_wr_saturated", stat_wr_cnt, 32'hFFFF_FFFF);
`endif

        // Reset while waiting in WR_B: everything drops at once, no response afterwards.
        @(negedge aclk);
        req_valid = 1; req_write = 1; req_addr = 12'h040; req_wdata = 32'h11223344; req_wstrb = 4'hF;
        @(posedge aclk);
        #1 req_valid = 0;
        @(negedge aclk);
        awready = 1; wready = 1;
        @(negedge aclk);
        awready = 0; wready = 0;
        chk("rstmid_bready_before", bready, 1);
        #2 aresetn = 0;
        #1;
        chk("rstmid_valids_dropped", {bready, awvalid, wvalid, arvalid, rready}, 5'b0);
        chk("rstmid_req_ready", req_ready, 1);
        @(negedge aclk);
        aresetn = 1;
        bvalid = 1; rvalid = 1; bresp = 2'b11; rresp = 2'b11;
        flag = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if (rsp_valid || bready || rready || !req_ready) flag = 1;
        end
        idle_inputs();
        chk("rstmid_no_rsp_and_stray_ignored", flag, 0);

        run_txn(vecs[5], o);
        check_txn("recover", vecs[5], o);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
